// File: rtl/mod_ram_dp_pkg.sv
// Shared types and helpers for the dual-port instruction/data memory.
package mod_ram_dp_pkg;

    typedef enum logic {
        S_CLR = 1'b0,
        S_RUN = 1'b1
    } state_t;

    localparam int BYTE_W = 8;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/inferred_ram_be.sv
// True dual-port array: port A registered read, port B registered read plus
// byte-enable write (read-first, so a same-edge read returns the old word).
module inferred_ram_be #(
    parameter int DEPTH  = 512,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int NB    = DATA_W / 8
) (
    input  logic                   clk,
    input  logic                   a_en,
    input  logic [AW-1:0]          a_addr,
    output logic [DATA_W-1:0]      a_q,
    input  logic                   b_en,
    input  logic [NB-1:0]          b_we,
    input  logic [AW-1:0]          b_addr,
    input  logic [NB-1:0][7:0]     b_d,
    output logic [DATA_W-1:0]      b_q
);

    logic [NB-1:0][7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (a_en)
            a_q <= mem[a_addr];
        if (b_en) begin
            for (int b = 0; b < NB; b++)
                if (b_we[b])
                    mem[b_addr][b] <= b_d[b];
            b_q <= mem[b_addr];
        end
    end

endmodule

// File: rtl/mod_ram_dp.sv
// Dual-port memory wrapper: clear sweep, alignment/fault tracking, ROM write
// blocking, write-to-instruction-read bypass and valid-gated outputs.
module mod_ram_dp
    import mod_ram_dp_pkg::*;
#(
    parameter int              DEPTH    = 512,
    parameter int              DATA_W   = 32,
    parameter bit              ROM_MODE = 1'b0,
    parameter bit              CLR_RST  = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ie,
    input  logic [31:0]         iaddr,
    input  logic                de,
    input  logic [31:0]         daddr,
    input  logic                drw,
    input  logic [DATA_W/8-1:0] dbe,
    input  logic [DATA_W-1:0]   din,
    output logic [DATA_W-1:0]   iout,
    output logic                ivalid,
    output logic [DATA_W-1:0]   dout,
    output logic                dvalid,
    output logic                ready,
    output logic                fault
);

    localparam int AW = addr_w(DEPTH);
    localparam int NB = DATA_W / BYTE_W;

    state_t                     state, state_nx;
    logic [AW-1:0]              cnt;
    logic [AW-1:0]              iidx, didx;
    logic                       i_rd, d_rd, d_wr, flt, sweep, byp;
    logic [NB-1:0][BYTE_W-1:0]  wmask;
    logic [DATA_W-1:0]          byp_d, byp_m, qa, qb;
    logic                       unused_addr;

    assign iidx        = iaddr[AW+1:2];
    assign didx        = daddr[AW+1:2];
    assign unused_addr = ^{iaddr[31:AW+2], daddr[31:AW+2]};

    assign sweep = (state == S_CLR) && !rst;
    assign i_rd  = ie && ready && (iaddr[1:0] == 2'b00);
    assign d_rd  = de && ready && (daddr[1:0] == 2'b00) && !drw;
    assign d_wr  = de && ready && (daddr[1:0] == 2'b00) && drw && !ROM_MODE;
    assign flt   = ready && ((ie && iaddr[1:0] != 2'b00) ||
                             (de && daddr[1:0] != 2'b00) ||
                             (de && drw && ROM_MODE));

    for (genvar b = 0; b < NB; b++) begin : g_mask
        assign wmask[b] = {BYTE_W{dbe[b]}};
    end

    always_comb begin
        state_nx = state;
        if (state == S_CLR && cnt == AW'(DEPTH - 1))
            state_nx = S_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CLR_RST ? S_CLR : S_RUN;
            cnt    <= '0;
            ready  <= 1'b0;
            ivalid <= 1'b0;
            dvalid <= 1'b0;
            fault  <= 1'b0;
            byp    <= 1'b0;
        end else begin
            state  <= state_nx;
            if (state == S_CLR)
                cnt <= cnt + 1'b1;
            ready  <= (state == S_RUN);
            ivalid <= i_rd;
            dvalid <= d_rd;
            fault  <= fault | flt;
            byp    <= i_rd && d_wr && (iidx == didx);
        end
    end

    // The array is read-first, so the bypass rebuilds the new word from the
    // old one plus the captured write bytes.
    always_ff @(posedge clk) begin
        byp_d <= din;
        byp_m <= wmask;
    end

    inferred_ram_be #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_ram (
        .clk    (clk),
        .a_en   (i_rd),
        .a_addr (iidx),
        .a_q    (qa),
        .b_en   (sweep || d_wr || d_rd),
        .b_we   (sweep ? {NB{1'b1}} : (d_wr ? dbe : {NB{1'b0}})),
        .b_addr (sweep ? cnt : didx),
        .b_d    (sweep ? INIT_VAL : din),
        .b_q    (qb)
    );

    assign iout = !ivalid ? '0 : (byp ? ((qa & ~byp_m) | (byp_d & byp_m)) : qa);
    assign dout = dvalid ? qb : '0;

endmodule
